// File: rtl/led_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : led_frame_buffer
//  Description : LED matrix frame buffer with a write port (overwrite, OR and
//                XOR read-modify-write), a registered read port for the scan
//                driver, and a one-pixel-per-cycle clear sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_frame_buffer #(
    parameter  int ROWS = 8,
    parameter  int COLS = 8,
    parameter  int DW   = 4,
    localparam int RAW  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CAW  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [1:0]     wr_mode,
    input  logic [RAW-1:0] wr_row,
    input  logic [CAW-1:0] wr_col,
    input  logic [DW-1:0]  wr_data,
    input  logic           rd_en,
    input  logic [RAW-1:0] rd_row,
    input  logic [CAW-1:0] rd_col,
    output logic [DW-1:0]  rd_data,
    output logic           rd_valid,
    input  logic           clr_req,
    output logic           busy
);

    localparam int              c_NPIX = ROWS * COLS;
    localparam int              c_IW   = (c_NPIX > 1) ? $clog2(c_NPIX) : 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(c_NPIX - 1);
    localparam logic [RAW:0]    c_ROWS = ROWS[RAW:0];
    localparam logic [CAW:0]    c_COLS = COLS[CAW:0];

    localparam logic [1:0] c_MODE_OVR = 2'b00;
    localparam logic [1:0] c_MODE_OR  = 2'b01;
    localparam logic [1:0] c_MODE_XOR = 2'b10;
    localparam logic [1:0] c_MODE_RSV = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t          r_state;
    logic [c_IW-1:0] r_cnt;
    logic            r_busy;
    logic [DW-1:0]   r_rd_data;
    logic            r_rd_valid;

    // Pixel storage carries no reset; the clear sweep initialises it.
    logic [DW-1:0]   r_mem [c_NPIX];

    logic            w_wr_in_range;
    logic            w_rd_in_range;
    logic            w_wr_ok;
    logic [c_IW-1:0] w_widx;
    logic [c_IW-1:0] w_ridx;
    logic [DW-1:0]   w_old;
    logic [DW-1:0]   w_new;

    assign w_wr_in_range = ({1'b0, wr_row} < c_ROWS) && ({1'b0, wr_col} < c_COLS);
    assign w_rd_in_range = ({1'b0, rd_row} < c_ROWS) && ({1'b0, rd_col} < c_COLS);
    assign w_widx        = c_IW'(wr_row) * c_IW'(COLS) + c_IW'(wr_col);
    assign w_ridx        = c_IW'(rd_row) * c_IW'(COLS) + c_IW'(rd_col);
    assign w_wr_ok       = wr_en && !r_busy && w_wr_in_range && (wr_mode != c_MODE_RSV);

    // The old value comes straight from the array, so a write in the previous
    // cycle is already visible and back-to-back RMW chains naturally.
    always_comb begin
        w_old = r_mem[w_widx];
        w_new = wr_data;
        unique case (wr_mode)
            c_MODE_OR:  w_new = wr_data | w_old;
            c_MODE_XOR: w_new = wr_data ^ w_old;
            c_MODE_OVR: w_new = wr_data;
            default:    w_new = wr_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_ok) begin
            r_mem[w_widx] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            unique case (r_state)
                S_CLEAR: begin
                    if (r_cnt == c_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (clr_req) begin
                        r_state <= S_CLEAR;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
            endcase
        end
    end

    // Array is sampled before this edge's write lands: read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= (r_busy || !w_rd_in_range) ? '0 : r_mem[w_ridx];
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;

endmodule
`default_nettype wire
